// File: rtl/gb_lcd_pixel_tx.sv
// DMG LCD pixel-stream transmitter: 2bpp row serialiser plus line/frame timing.
// Optional test-pattern source is enabled by defining GB_LCD_TX_TESTPAT_EN.
module gb_lcd_pixel_tx #(
  parameter int DOTS_PER_LINE   = 456,
  parameter int LINES_PER_FRAME = 154,
  parameter int VISIBLE_LINES   = 144,
  parameter int OAM_DOTS        = 80,
  parameter int LINE_PIXELS     = 160
) (
  input  logic       GameBoy_clk,
  input  logic       GameBoy_reset_n,
  input  logic       lcd_en,
  input  logic [7:0] row_lo,
  input  logic [7:0] row_hi,
  input  logic       row_valid,
  output logic       row_ready,
  output logic [1:0] LD,
  output logic       PX_VALID,
  output logic [7:0] LY,
  output logic [1:0] mode,
  output logic       vblank_irq,
  output logic       underrun,
  input  logic       underrun_clr
`ifdef GB_LCD_TX_TESTPAT_EN
  ,
  input  logic       test_pat_en
`endif
);

  localparam int DW = $clog2(DOTS_PER_LINE);
  localparam int CW = $clog2(LINE_PIXELS + 1);
  localparam int RW = DW + 2;

  typedef enum logic [1:0] {
    M_HBLANK = 2'd0,
    M_VBLANK = 2'd1,
    M_OAM    = 2'd2,
    M_XFER   = 2'd3
  } mode_e;

  mode_e         mode_q, mode_d;
  logic          run_q, run_d;
  logic [DW-1:0] dot_q, dot_d;
  logic [7:0]    ly_q, ly_d;
  logic [CW-1:0] pcnt_q, pcnt_d;
  logic [7:0]    sh_lo_q, sh_lo_d;
  logic [7:0]    sh_hi_q, sh_hi_d;
  logic [3:0]    sh_cnt_q, sh_cnt_d;
  logic [7:0]    hd_lo_q, hd_lo_d;
  logic [7:0]    hd_hi_q, hd_hi_d;
  logic          hd_full_q, hd_full_d;
  logic [1:0]    ld_q, ld_d;
  logic          pxv_q, pxv_d;
  logic          irq_q, irq_d;
  logic          unr_q, unr_d;
  logic          rdy_q, rdy_d;

  logic          tp, wrap, vis, xfer, force_px;
  logic          shift, zero_px, keep, accept;
  logic [RW-1:0] rem_dots, rem_px;

`ifdef GB_LCD_TX_TESTPAT_EN
  assign tp = test_pat_en;
`else
  assign tp = 1'b0;
`endif

  always_comb begin
    run_d     = run_q;
    dot_d     = dot_q;
    ly_d      = ly_q;
    pcnt_d    = pcnt_q;
    sh_lo_d   = sh_lo_q;
    sh_hi_d   = sh_hi_q;
    sh_cnt_d  = sh_cnt_q;
    hd_lo_d   = hd_lo_q;
    hd_hi_d   = hd_hi_q;
    hd_full_d = hd_full_q;
    ld_d      = 2'd0;
    pxv_d     = 1'b0;
    unr_d     = unr_q;
    wrap      = 1'b0;
    shift     = 1'b0;
    zero_px   = 1'b0;

    if (!lcd_en) begin
      run_d = 1'b0;
      dot_d = '0;
      ly_d  = 8'd0;
    end else if (!run_q) begin
      run_d = 1'b1;
      dot_d = '0;
      ly_d  = 8'd0;
    end else if (dot_q == DW'(DOTS_PER_LINE - 1)) begin
      dot_d = '0;
      wrap  = 1'b1;
      if (ly_q == 8'(LINES_PER_FRAME - 1)) ly_d = 8'd0;
      else ly_d = ly_q + 8'd1;
    end else begin
      dot_d = dot_q + DW'(1);
    end

    vis  = ly_d < 8'(VISIBLE_LINES);
    xfer = run_d && vis && (dot_d >= DW'(OAM_DOTS)) &&
           (pcnt_q < CW'(LINE_PIXELS));

    // force once remaining dots no longer exceed remaining pixels
    rem_dots = RW'(DOTS_PER_LINE) - RW'(dot_d);
    rem_px   = RW'(LINE_PIXELS) - RW'(pcnt_q);
    force_px = xfer && (rem_dots <= rem_px);

    if (!run_d) mode_d = M_HBLANK;
    else if (!vis) mode_d = M_VBLANK;
    else if (xfer) mode_d = M_XFER;
    else if (dot_d < DW'(OAM_DOTS)) mode_d = M_OAM;
    else mode_d = M_HBLANK;

    if (xfer) begin
      if (tp) begin
        pxv_d  = 1'b1;
        ld_d   = pcnt_q[4:3] ^ ly_d[4:3];
        pcnt_d = pcnt_q + CW'(1);
      end else if (sh_cnt_q != 4'd0) begin
        pxv_d  = 1'b1;
        ld_d   = {sh_hi_q[7], sh_lo_q[7]};
        shift  = 1'b1;
        pcnt_d = pcnt_q + CW'(1);
      end else if (force_px) begin
        pxv_d   = 1'b1;
        zero_px = 1'b1;
        pcnt_d  = pcnt_q + CW'(1);
      end
    end

    if (shift) begin
      sh_lo_d  = {sh_lo_q[6:0], 1'b0};
      sh_hi_d  = {sh_hi_q[6:0], 1'b0};
      sh_cnt_d = sh_cnt_q - 4'd1;
    end

    if (hd_full_q && (sh_cnt_q == 4'd0 ||
        (shift && sh_cnt_q == 4'd1))) begin
      sh_lo_d   = hd_lo_q;
      sh_hi_d   = hd_hi_q;
      sh_cnt_d  = 4'd8;
      hd_full_d = 1'b0;
    end

    keep = (mode_d == M_OAM) || (mode_d == M_XFER);

    // HBlank, VBlank, disable and every line start drop buffered pixels
    if (!keep || dot_d == '0 || tp) begin
      sh_lo_d   = 8'd0;
      sh_hi_d   = 8'd0;
      sh_cnt_d  = 4'd0;
      hd_lo_d   = 8'd0;
      hd_hi_d   = 8'd0;
      hd_full_d = 1'b0;
    end

    if (!run_d || dot_d == '0) pcnt_d = '0;

    accept = row_valid && rdy_q && !tp;
    if (accept && keep) begin
      hd_lo_d   = row_lo;
      hd_hi_d   = row_hi;
      hd_full_d = 1'b1;
    end

    rdy_d = !hd_full_d && keep && lcd_en && !tp;
    irq_d = wrap && (ly_d == 8'(VISIBLE_LINES));

    if (underrun_clr) unr_d = 1'b0;
    if (zero_px) unr_d = 1'b1;
  end

  always_ff @(posedge GameBoy_clk or negedge GameBoy_reset_n) begin
    if (!GameBoy_reset_n) begin
      run_q     <= 1'b0;
      dot_q     <= '0;
      ly_q      <= 8'd0;
      mode_q    <= M_HBLANK;
      pcnt_q    <= '0;
      sh_lo_q   <= 8'd0;
      sh_hi_q   <= 8'd0;
      sh_cnt_q  <= 4'd0;
      hd_lo_q   <= 8'd0;
      hd_hi_q   <= 8'd0;
      hd_full_q <= 1'b0;
      ld_q      <= 2'd0;
      pxv_q     <= 1'b0;
      irq_q     <= 1'b0;
      unr_q     <= 1'b0;
      rdy_q     <= 1'b0;
    end else begin
      run_q     <= run_d;
      dot_q     <= dot_d;
      ly_q      <= ly_d;
      mode_q    <= mode_d;
      pcnt_q    <= pcnt_d;
      sh_lo_q   <= sh_lo_d;
      sh_hi_q   <= sh_hi_d;
      sh_cnt_q  <= sh_cnt_d;
      hd_lo_q   <= hd_lo_d;
      hd_hi_q   <= hd_hi_d;
      hd_full_q <= hd_full_d;
      ld_q      <= ld_d;
      pxv_q     <= pxv_d;
      irq_q     <= irq_d;
      unr_q     <= unr_d;
      rdy_q     <= rdy_d;
    end
  end

  assign row_ready  = rdy_q;
  assign LD         = ld_q;
  assign PX_VALID   = pxv_q;
  assign LY         = ly_q;
  assign mode       = mode_q;
  assign vblank_irq = irq_q;
  assign underrun   = unr_q;

endmodule

// File: tb/tb_gb_lcd_pixel_tx.sv
// Directed bench for gb_lcd_pixel_tx: reset, starvation, disable,
// a full continuous frame and (with GB_LCD_TX_TESTPAT_EN) the test pattern.
module tb_gb_lcd_pixel_tx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       lcd_en = 1'b0;
  logic [7:0] row_lo = 8'hF0;
  logic [7:0] row_hi = 8'hCC;
  logic       row_valid = 1'b0;
  logic       underrun_clr = 1'b0;
`ifdef GB_LCD_TX_TESTPAT_EN
  logic       test_pat_en = 1'b0;
`endif
  logic       row_ready;
  logic [1:0] LD;
  logic       PX_VALID;
  logic [7:0] LY;
  logic [1:0] mode;
  logic       vblank_irq;
  logic       underrun;

  int checks = 0;
  int errors = 0;
  bit acc;
  int nacc = 0;
  int bdot = 0;
  int bly = 0;

  gb_lcd_pixel_tx dut (
    .GameBoy_clk     (clk),
    .GameBoy_reset_n (rst_n),
    .lcd_en          (lcd_en),
    .row_lo          (row_lo),
    .row_hi          (row_hi),
    .row_valid       (row_valid),
    .row_ready       (row_ready),
    .LD              (LD),
    .PX_VALID        (PX_VALID),
    .LY              (LY),
    .mode            (mode),
    .vblank_irq      (vblank_irq),
    .underrun        (underrun),
    .underrun_clr    (underrun_clr)
`ifdef GB_LCD_TX_TESTPAT_EN
    ,
    .test_pat_en     (test_pat_en)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #1500000;
    $display("FAIL timeout got running exp finished");
    $fatal(1);
  end

  // F0/CC rows serialise MSB first as 3,3,1,1,2,2,0,0
  function automatic logic [1:0] pat(input int i);
    case (i % 8)
      0, 1:    pat = 2'd3;
      2, 3:    pat = 2'd1;
      4, 5:    pat = 2'd2;
      default: pat = 2'd0;
    endcase
  endfunction

  task automatic step(input bit restart);
    @(negedge clk);
    acc = row_valid & row_ready;
    @(posedge clk);
    #1;
    if (acc) nacc++;
    if (restart) begin
      bdot = 0;
      bly  = 0;
    end else if (bdot == 455) begin
      bdot = 0;
      bly  = (bly == 153) ? 0 : bly + 1;
    end else begin
      bdot++;
    end
  endtask

  task automatic test_reset();
    logic [14:0] v;
    rst_n  = 1'b0;
    lcd_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    v = {row_ready, LD, PX_VALID, LY, mode, vblank_irq, underrun};
    checks++;
    if (v !== 15'd0) begin
      errors++;
      $display("FAIL reset_outs got %h exp 0", v);
    end
    lcd_en    = 1'b1;
    row_valid = 1'b1;
    rst_n     = 1'b1;
    step(1);
    checks++;
    if (mode !== 2'd2 || LY !== 8'd0) begin
      errors++;
      $display("FAIL en_start got mode %0d LY %0d exp 2 0", mode, LY);
    end
    checks++;
    if (row_ready !== 1'b1 || PX_VALID !== 1'b0) begin
      errors++;
      $display("FAIL en_ready got %b%b exp 10", row_ready, PX_VALID);
    end
    repeat (99) step(0);
    checks++;
    if (mode !== 2'd3 || PX_VALID !== 1'b1) begin
      errors++;
      $display("FAIL pre_rst got mode %0d pxv %b exp 3 1", mode, PX_VALID);
    end
    #2 rst_n = 1'b0;
    #1;
    v = {row_ready, LD, PX_VALID, LY, mode, vblank_irq, underrun};
    checks++;
    if (v !== 15'd0) begin
      errors++;
      $display("FAIL async_rst got %h exp 0", v);
    end
    row_valid = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_full_starvation();
    int npx = 0;
    int bad = 0;
    int badld = 0;
    int badm = 0;
    logic u295 = 1'b1;
    logic u296 = 1'b0;
    for (int d = 0; d < 456; d++) begin
      step(d == 0);
      if (PX_VALID !== (bdot >= 296)) bad++;
      if (PX_VALID === 1'b1 && LD !== 2'd0) badld++;
      if (mode !== ((bdot < 80) ? 2'd2 : 2'd3)) badm++;
      if (PX_VALID === 1'b1) npx++;
      if (bdot == 295) u295 = underrun;
      if (bdot == 296) u296 = underrun;
    end
    checks++;
    if (npx != 160) begin
      errors++;
      $display("FAIL starve_cnt got %0d exp 160", npx);
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL starve_pos got %0d bad exp 0", bad);
    end
    checks++;
    if (badld != 0) begin
      errors++;
      $display("FAIL starve_ld got %0d bad exp 0", badld);
    end
    checks++;
    if (badm != 0) begin
      errors++;
      $display("FAIL starve_mode got %0d bad exp 0", badm);
    end
    checks++;
    if (u295 !== 1'b0 || u296 !== 1'b1) begin
      errors++;
      $display("FAIL starve_unr got %b%b exp 01", u295, u296);
    end
  endtask

  task automatic test_partial_starvation();
    int npx = 0;
    int bad = 0;
    int badld = 0;
    logic u1 = 1'b1;
    logic u375 = 1'b1;
    logic u376 = 1'b0;
    logic [1:0] e;
    logic ev;
    nacc = 0;
    for (int d = 0; d < 456; d++) begin
      row_valid    = (nacc < 10);
      underrun_clr = (d >= 1 && d <= 376);
      step(0);
      ev = (bdot >= 80 && bdot < 160) || bdot >= 376;
      e  = (bdot < 160) ? pat(bdot - 80) : 2'd0;
      if (PX_VALID !== ev) bad++;
      if (PX_VALID === 1'b1 && LD !== e) badld++;
      if (PX_VALID === 1'b1) npx++;
      if (bdot == 1) u1 = underrun;
      if (bdot == 375) u375 = underrun;
      if (bdot == 376) u376 = underrun;
    end
    underrun_clr = 1'b0;
    checks++;
    if (npx != 160) begin
      errors++;
      $display("FAIL part_cnt got %0d exp 160", npx);
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL part_pos got %0d bad exp 0", bad);
    end
    checks++;
    if (badld != 0) begin
      errors++;
      $display("FAIL part_ld got %0d bad exp 0", badld);
    end
    checks++;
    if (nacc != 10) begin
      errors++;
      $display("FAIL part_rows got %0d exp 10", nacc);
    end
    checks++;
    if ({u1, u375, u376} !== 3'b001) begin
      errors++;
      $display("FAIL part_unr got %b%b%b exp 001", u1, u375, u376);
    end
    checks++;
    if (LY !== 8'd1) begin
      errors++;
      $display("FAIL part_ly got %0d exp 1", LY);
    end
  endtask

  task automatic test_disable();
    row_valid = 1'b1;
    while (!(bly == 4 && bdot == 150)) step(0);
    checks++;
    if (mode !== 2'd3 || PX_VALID !== 1'b1 || LY !== 8'd4) begin
      errors++;
      $display("FAIL dis_pre got %0d %b %0d exp 3 1 4", mode, PX_VALID, LY);
    end
    lcd_en = 1'b0;
    step(1);
    checks++;
    if (PX_VALID !== 1'b0 || LY !== 8'd0 || mode !== 2'd0) begin
      errors++;
      $display("FAIL dis_idle got %b %0d %0d exp 0 0 0", PX_VALID, LY, mode);
    end
    checks++;
    if (row_ready !== 1'b0 || underrun !== 1'b1) begin
      errors++;
      $display("FAIL dis_flags got %b%b exp 01", row_ready, underrun);
    end
    underrun_clr = 1'b1;
    step(1);
    underrun_clr = 1'b0;
    checks++;
    if (underrun !== 1'b0 || mode !== 2'd0) begin
      errors++;
      $display("FAIL dis_clr got %b %0d exp 0 0", underrun, mode);
    end
    lcd_en = 1'b1;
    step(1);
    checks++;
    if (mode !== 2'd2 || LY !== 8'd0 || row_ready !== 1'b1) begin
      errors++;
      $display("FAIL reen got %0d %0d %b exp 2 0 1", mode, LY, row_ready);
    end
  endtask

  task automatic test_continuous_frame();
    int total = 0;
    int lp = 0;
    int bad = 0;
    int badld = 0;
    int badm = 0;
    int badline = 0;
    int badly = 0;
    int irqs = 0;
    int badirq = 0;
    int badunr = 0;
    logic vis;
    logic ev;
    logic [1:0] em;
    for (int i = 0; i < 70224; i++) begin
      if (i > 0) step(0);
      vis = (bly < 144);
      ev  = vis && bdot >= 80 && bdot < 240;
      if (!vis) em = 2'd1;
      else if (bdot < 80) em = 2'd2;
      else if (bdot < 240) em = 2'd3;
      else em = 2'd0;
      if (bdot == 0) lp = 0;
      if (PX_VALID !== ev) bad++;
      if (mode !== em) badm++;
      if (LY !== 8'(bly)) badly++;
      if (PX_VALID === 1'b1) begin
        if (LD !== pat(lp)) badld++;
        lp++;
        total++;
      end
      if (bdot == 455 && vis && lp != 160) badline++;
      if (vblank_irq === 1'b1) irqs++;
      if (vblank_irq !== (bly == 144 && bdot == 0)) badirq++;
      if (underrun !== 1'b0) badunr++;
    end
    checks++;
    if (total != 23040) begin
      errors++;
      $display("FAIL frame_cnt got %0d exp 23040", total);
    end
    checks++;
    if (bad != 0 || badline != 0) begin
      errors++;
      $display("FAIL frame_pos got %0d/%0d exp 0/0", bad, badline);
    end
    checks++;
    if (badld != 0) begin
      errors++;
      $display("FAIL frame_ld got %0d bad exp 0", badld);
    end
    checks++;
    if (badm != 0 || badly != 0) begin
      errors++;
      $display("FAIL frame_mode got %0d/%0d exp 0/0", badm, badly);
    end
    checks++;
    if (irqs != 1 || badirq != 0) begin
      errors++;
      $display("FAIL frame_irq got %0d/%0d exp 1/0", irqs, badirq);
    end
    checks++;
    if (badunr != 0) begin
      errors++;
      $display("FAIL frame_unr got %0d exp 0", badunr);
    end
  endtask

`ifdef GB_LCD_TX_TESTPAT_EN
  task automatic test_pattern();
    int nrdy = 0;
    int bad = 0;
    int badld = 0;
    int p;
    logic [7:0] pv;
    logic [7:0] lv;
    logic [1:0] e;
    logic [1:0] l00 = 2'd3;
    logic [1:0] l08 = 2'd3;
    logic [1:0] l80 = 2'd3;
    test_pat_en = 1'b1;
    for (int i = 0; i < 9 * 456; i++) begin
      step(0);
      if (row_ready !== 1'b0) nrdy++;
      if (PX_VALID !== (bly < 144 && bdot >= 80 && bdot < 240)) bad++;
      if (PX_VALID === 1'b1) begin
        p  = bdot - 80;
        pv = 8'(p);
        lv = 8'(bly);
        e  = pv[4:3] ^ lv[4:3];
        if (LD !== e) badld++;
        if (bly == 0 && p == 0) l00 = LD;
        if (bly == 0 && p == 8) l08 = LD;
        if (bly == 8 && p == 0) l80 = LD;
      end
    end
    test_pat_en = 1'b0;
    checks++;
    if (nrdy != 0) begin
      errors++;
      $display("FAIL tp_ready got %0d exp 0", nrdy);
    end
    checks++;
    if (bad != 0 || badld != 0) begin
      errors++;
      $display("FAIL tp_pix got %0d/%0d exp 0/0", bad, badld);
    end
    checks++;
    if (l00 !== 2'd0 || l08 !== 2'd1 || l80 !== 2'd1) begin
      errors++;
      $display("FAIL tp_ld got %0d %0d %0d exp 0 1 1", l00, l08, l80);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_full_starvation();
    test_partial_starvation();
    test_disable();
    test_continuous_frame();
`ifdef GB_LCD_TX_TESTPAT_EN
    test_pattern();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
